dyt_execute_stage: RTL
======================

# dyt_execute_stage

Execute stage of the dyt RISC-V pipeline. It accepts decoded instructions from decode over a valid/ready handshake, selects ALU operands and drives the ALU through the `dyt_alu_if` CPU modport. It resolves branch/jump conditions from the ALU flags and result, then registers results into a 2-entry output buffer that feeds the memory stage. Taken control transfers produce a one-cycle redirect to fetch.

## Interface
Parameters:
- `BUF_DEPTH`, 2: output buffer entries; fixed at 2, no other value supported.

Ports (`word_t` = 32 bits):
- `CLK`  in  1  clock; all state on rising edge. One clock domain.
- `nRST`  in  1  asynchronous, active-low reset.
- `aluif`  modport  `dyt_alu_if.cpu`  drives `alu_port_0`, `alu_port_1`, `alu_op`; reads `alu_port_out`, `alu_zero`, `alu_negative`, `alu_overflow`.
- `flush`  in  1  discard all buffered and incoming instructions this cycle.
- `id_valid`  in  1  decode presents an instruction.
- `id_ready`  out  1  stage accepts; transfer when `id_valid & id_ready`.
- `id_pc`, `id_rs1_data`, `id_rs2_data`, `id_imm`  in  32 each  operands.
- `id_src_a`  in  `src_a_t`  SRC_A_RS1 / SRC_A_PC / SRC_A_ZERO.
- `id_src_b`  in  `src_b_t`  SRC_B_RS2 / SRC_B_IMM / SRC_B_FOUR.
- `id_alu_op`  in  `alu_op_t`  operation for non-branch instructions.
- `id_br`  in  `br_t`  BR_NONE, BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL, JALR.
- `id_rd`  in  5  destination register; `id_wen` in 1 writes rd.
- `ex_valid`  out  1  head entry valid; `ex_ready` in 1 memory stage pops.
- `ex_result`  out  32; `ex_store_data` out 32; `ex_rd` out 5; `ex_wen` out 1.
- `ex_redirect`  out  1  one-cycle taken-transfer pulse; `ex_target` out 32.

## Operation
- Operand mux: `alu_port_0` = rs1 / pc / 0 and `alu_port_1` = rs2 / imm / 4, chosen by `id_src_a` / `id_src_b`.
- Conditional branches override `alu_op` and force rs1/rs2 operands:
  - BEQ/BNE/BLT/BGE use ALU_SUB.
  - BLTU/BGEU use ALU_SLTU.
- Branch taken conditions:
  - BEQ: zero.
  - BNE: !zero.
  - BLT: negative^overflow.
  - BGE: !(negative^overflow).
  - BLTU: result != 0.
  - BGEU: result == 0.
- JAL and JALR always take. Decode supplies pc/4 operands, so the ALU produces the link value pc+4.
- Target computation uses a local 32-bit adder, wrap-around modulo 2^32:
  - Branches and JAL: pc+imm.
  - JALR: (rs1+imm) & ~1.
- Stored result per entry:
  - Conditional branches: `ex_result` = 0 and `ex_wen` forced 0.
  - All other instructions: `ex_result` = `alu_port_out`.
- `ex_store_data` = rs2.
- Output buffer: 2-entry FIFO with count 0..2. `id_ready` = (count < 2) & !flush, and depends on registered count only; a pop does not open a slot in the same cycle.
- Same-cycle push and pop at count 1 keeps count at 1, and order is preserved.
- Redirect: on accepting a taken instruction, `ex_redirect` = 1 and `ex_target` are registered for exactly the next cycle.
- Younger-instruction squash: an instruction accepted in a cycle where `ex_redirect` = 1 is dropped. It is not buffered and does not redirect.
- `flush`: count goes to 0 on the next edge, any same-cycle acceptance is dropped, and a pending redirect is cleared.
- `flush` and `ex_ready` together: `flush` wins.

## Timing
- Reset, asynchronous on `nRST` low: count = 0, `ex_valid` = 0, `ex_redirect` = 0, `ex_target` = 0. Buffer contents are 0, so `ex_result`/`ex_store_data`/`ex_rd`/`ex_wen` read 0.
- Latency: accepted at edge N → `ex_valid` = 1 with the result during cycle N+1, if the buffer was empty.
- `ex_redirect` is asserted during cycle N+1 for exactly 1 cycle.
- ALU path is combinational within the acceptance cycle. The ALU has no state.
- Back-to-back issue at 1/cycle while `ex_ready` = 1.
- Reset deasserted mid-stream: the first acceptance is possible on the first edge after `nRST` rises.

## Structure
- `common_types` package gains `src_a_t`, `src_b_t`, `br_t`. `alu_op_t` and `word_t` are reused.
- Sub-module `dyt_ex_buffer`: the 2-entry FIFO, holding {result, store_data, rd, wen}.
- Branch evaluation and operand muxing stay in `dyt_execute_stage`.

## Test plan
- ADD: rs1=5, rs2=7, SRC_A_RS1, SRC_B_RS2 → `ex_result` = 12 at N+1, `ex_wen` = 1, no redirect.
- BLT: rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20 → `ex_redirect` pulse at N+1, `ex_target` = 0x120, `ex_wen` = 0.
- BLT with the same rs1/rs2 but BLTU → not taken.
- JALR: rs1=0x1001, imm=2 → `ex_target` = 0x1002, `ex_result` = pc+4.
- Squash: the instruction after a taken BEQ is accepted during the redirect cycle → it never appears on `ex_valid`.
- Backpressure: hold `ex_ready` = 0 and push 3 → `id_ready` drops after 2. Release → pops occur in order, and `id_ready` returns the cycle after the first pop.
- Flush with 2 buffered plus a concurrent `id_valid` → `ex_valid` = 0 next cycle. Separately, `nRST` pulsed mid-stream → all outputs 0 asynchronously.

Source files
------------

// File: rtl/common_types.sv
// Shared types for the dyt pipeline: machine word, ALU operations, execute-stage
// operand selects, branch kinds and the execute output-buffer entry.
package common_types;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_op_t;

    typedef enum logic [1:0] {SRC_A_RS1, SRC_A_PC, SRC_A_ZERO} src_a_t;
    typedef enum logic [1:0] {SRC_B_RS2, SRC_B_IMM, SRC_B_FOUR} src_b_t;

    typedef enum logic [3:0] {
        BR_NONE, BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL, JALR
    } br_t;

    typedef struct packed {
        word_t      result;
        word_t      store_data;
        logic [4:0] rd;
        logic       wen;
    } ex_entry_t;

    function automatic logic is_cond_branch(br_t br);
        return (br == BEQ) || (br == BNE) || (br == BLT) ||
               (br == BGE) || (br == BLTU) || (br == BGEU);
    endfunction

endpackage

// File: rtl/dyt_alu_if.sv
// Connection between a pipeline stage and the stateless ALU.
// The cpu side drives operands and op; the alu side returns result and flags.
interface dyt_alu_if;
    import common_types::*;

    word_t   alu_port_0;
    word_t   alu_port_1;
    alu_op_t alu_op;
    word_t   alu_port_out;
    logic    alu_zero;
    logic    alu_negative;
    logic    alu_overflow;

    modport cpu (
        output alu_port_0, alu_port_1, alu_op,
        input  alu_port_out, alu_zero, alu_negative, alu_overflow
    );

    modport alu (
        input  alu_port_0, alu_port_1, alu_op,
        output alu_port_out, alu_zero, alu_negative, alu_overflow
    );
endinterface

// File: rtl/dyt_ex_buffer.sv
// Two-entry FIFO between execute and memory. Flush empties it; push is ignored
// when full and pop when empty, so callers may pass raw requests.
module dyt_ex_buffer
    import common_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      flush,
    input  logic      push,
    input  logic      pop,
    input  ex_entry_t din,
    output ex_entry_t head,
    output logic      valid,
    output logic      full
);

    ex_entry_t  mem [DEPTH];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       do_push;
    logic       do_pop;

    assign valid   = (count != 2'd0);
    assign full    = (count == DEPTH[1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & valid;
    assign head    = mem[rd_ptr];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dyt_execute_stage.sv
// Execute stage: operand muxing, ALU drive, branch resolution, target adder,
// squash of the instruction behind a taken transfer, and the output buffer.
module dyt_execute_stage
    import common_types::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic       CLK,
    input  logic       nRST,
    dyt_alu_if.cpu     aluif,
    input  logic       flush,
    input  logic       id_valid,
    output logic       id_ready,
    input  word_t      id_pc,
    input  word_t      id_rs1_data,
    input  word_t      id_rs2_data,
    input  word_t      id_imm,
    input  src_a_t     id_src_a,
    input  src_b_t     id_src_b,
    input  alu_op_t    id_alu_op,
    input  br_t        id_br,
    input  logic [4:0] id_rd,
    input  logic       id_wen,
    output logic       ex_valid,
    input  logic       ex_ready,
    output word_t      ex_result,
    output word_t      ex_store_data,
    output logic [4:0] ex_rd,
    output logic       ex_wen,
    output logic       ex_redirect,
    output word_t      ex_target
);

    logic      is_cond;
    logic      taken;
    logic      buf_full;
    logic      accept;
    logic      keep;
    word_t     tgt_base;
    word_t     tgt_sum;
    word_t     target;
    ex_entry_t entry;
    ex_entry_t head;

    assign is_cond = is_cond_branch(id_br);

    // Conditional branches always compare rs1 against rs2, whatever decode selected.
    always_comb begin
        aluif.alu_port_0 = id_rs1_data;
        aluif.alu_port_1 = id_rs2_data;
        aluif.alu_op     = id_alu_op;
        if (!is_cond) begin
            case (id_src_a)
                SRC_A_PC:   aluif.alu_port_0 = id_pc;
                SRC_A_ZERO: aluif.alu_port_0 = '0;
                default:    aluif.alu_port_0 = id_rs1_data;
            endcase
            case (id_src_b)
                SRC_B_IMM:  aluif.alu_port_1 = id_imm;
                SRC_B_FOUR: aluif.alu_port_1 = 32'd4;
                default:    aluif.alu_port_1 = id_rs2_data;
            endcase
        end
        case (id_br)
            BEQ, BNE, BLT, BGE: aluif.alu_op = ALU_SUB;
            BLTU, BGEU:         aluif.alu_op = ALU_SLTU;
            default:            aluif.alu_op = id_alu_op;
        endcase
    end

    always_comb begin
        case (id_br)
            BEQ:       taken = aluif.alu_zero;
            BNE:       taken = ~aluif.alu_zero;
            BLT:       taken = aluif.alu_negative ^ aluif.alu_overflow;
            BGE:       taken = ~(aluif.alu_negative ^ aluif.alu_overflow);
            BLTU:      taken = (aluif.alu_port_out != '0);
            BGEU:      taken = (aluif.alu_port_out == '0);
            JAL, JALR: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

    assign tgt_base = (id_br == JALR) ? id_rs1_data : id_pc;
    assign tgt_sum  = tgt_base + id_imm;
    assign target   = (id_br == JALR) ? {tgt_sum[31:1], 1'b0} : tgt_sum;

    // Readiness looks only at registered occupancy, never at this cycle's pop.
    assign id_ready = ~buf_full & ~flush;
    assign accept   = id_valid & id_ready;
    assign keep     = accept & ~ex_redirect;

    assign entry.result     = is_cond ? '0 : aluif.alu_port_out;
    assign entry.store_data = id_rs2_data;
    assign entry.rd         = id_rd;
    assign entry.wen        = is_cond ? 1'b0 : id_wen;

    dyt_ex_buffer #(.DEPTH(BUF_DEPTH)) u_buffer (
        .CLK   (CLK),
        .nRST  (nRST),
        .flush (flush),
        .push  (keep),
        .pop   (ex_ready),
        .din   (entry),
        .head  (head),
        .valid (ex_valid),
        .full  (buf_full)
    );

    assign ex_result     = head.result;
    assign ex_store_data = head.store_data;
    assign ex_rd         = head.rd;
    assign ex_wen        = head.wen;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ex_redirect <= 1'b0;
            ex_target   <= '0;
        end else if (flush) begin
            ex_redirect <= 1'b0;
        end else begin
            ex_redirect <= keep & taken;
            if (keep & taken) ex_target <= target;
        end
    end

endmodule
